// File: rtl/hack_keyboard.sv
// hack_keyboard: PS/2 scan-code-set-2 receiver and Hack key-code mapper.
// Receives 11-bit frames from the keyboard, tracks E0/F0 prefixes and the
// shift keys, and holds the Hack code of the currently held key on
// hack_scancode (0 when no mapped key is held).
// Optional feature macro: HACK_KBD_PARITY_CHECK_EN (enforce odd parity).
module hack_keyboard #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] hack_scancode,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic ps2_fall;

  frame_state_t state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      rx_byte, rx_byte_n;
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            byte_valid, byte_valid_n;
  logic            frame_err_n;
  logic            parity_ok;

  logic       ext_flag, brk_flag, l_shift, r_shift;
  logic [7:0] make_code, lo_code, hi_code;

  // Map one set-2 key to its Hack code; 0 means the key is unmapped.
  function automatic logic [7:0] map_key(input logic ext, input logic shift,
                                         input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    if (ext) begin
      case (code)
        8'h5A: m = 8'd128;
        8'h6B: m = 8'd130;
        8'h75: m = 8'd131;
        8'h74: m = 8'd132;
        8'h72: m = 8'd133;
        8'h6C: m = 8'd134;
        8'h69: m = 8'd135;
        8'h7D: m = 8'd136;
        8'h7A: m = 8'd137;
        8'h70: m = 8'd138;
        8'h71: m = 8'd139;
        default: m = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: m = 8'h61; 8'h32: m = 8'h62; 8'h21: m = 8'h63; 8'h23: m = 8'h64;
        8'h24: m = 8'h65; 8'h2B: m = 8'h66; 8'h34: m = 8'h67; 8'h33: m = 8'h68;
        8'h43: m = 8'h69; 8'h3B: m = 8'h6A; 8'h42: m = 8'h6B; 8'h4B: m = 8'h6C;
        8'h3A: m = 8'h6D; 8'h31: m = 8'h6E; 8'h44: m = 8'h6F; 8'h4D: m = 8'h70;
        8'h15: m = 8'h71; 8'h2D: m = 8'h72; 8'h1B: m = 8'h73; 8'h2C: m = 8'h74;
        8'h3C: m = 8'h75; 8'h2A: m = 8'h76; 8'h1D: m = 8'h77; 8'h22: m = 8'h78;
        8'h35: m = 8'h79; 8'h1A: m = 8'h7A;
        8'h45: m = shift ? 8'h29 : 8'h30;
        8'h16: m = shift ? 8'h21 : 8'h31;
        8'h1E: m = shift ? 8'h40 : 8'h32;
        8'h26: m = shift ? 8'h23 : 8'h33;
        8'h25: m = shift ? 8'h24 : 8'h34;
        8'h2E: m = shift ? 8'h25 : 8'h35;
        8'h36: m = shift ? 8'h5E : 8'h36;
        8'h3D: m = shift ? 8'h26 : 8'h37;
        8'h3E: m = shift ? 8'h2A : 8'h38;
        8'h46: m = shift ? 8'h28 : 8'h39;
        8'h0E: m = shift ? 8'h7E : 8'h60;
        8'h4E: m = shift ? 8'h5F : 8'h2D;
        8'h55: m = shift ? 8'h2B : 8'h3D;
        8'h54: m = shift ? 8'h7B : 8'h5B;
        8'h5B: m = shift ? 8'h7D : 8'h5D;
        8'h5D: m = shift ? 8'h7C : 8'h5C;
        8'h4C: m = shift ? 8'h3A : 8'h3B;
        8'h52: m = shift ? 8'h22 : 8'h27;
        8'h41: m = shift ? 8'h3C : 8'h2C;
        8'h49: m = shift ? 8'h3E : 8'h2E;
        8'h4A: m = shift ? 8'h3F : 8'h2F;
        8'h29: m = 8'h20;
        8'h5A: m = 8'd128;
        8'h66: m = 8'd129;
        8'h76: m = 8'd140;
        8'h05: m = 8'd141; 8'h06: m = 8'd142; 8'h04: m = 8'd143; 8'h0C: m = 8'd144;
        8'h03: m = 8'd145; 8'h0B: m = 8'd146; 8'h83: m = 8'd147; 8'h0A: m = 8'd148;
        8'h01: m = 8'd149; 8'h09: m = 8'd150; 8'h78: m = 8'd151; 8'h07: m = 8'd152;
        default: m = 8'h00;
      endcase
      // Only lowercase letters land in 0x61-0x7A; shifted symbols sit outside it
      if (shift && m >= 8'h61 && m <= 8'h7A) m = m - 8'h20;
    end
    return m;
  endfunction

  // Two-flop synchronizers; lines idle high so reset to 1 avoids a false edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign ps2_fall = clk_prev & ~clk_s2;

`ifdef HACK_KBD_PARITY_CHECK_EN
  logic parity_bit, parity_bit_n;
  assign parity_ok = ^{rx_shift, parity_bit};

  // Parity bit capture register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_bit <= 1'b0;
    else       parity_bit <= parity_bit_n;
  end
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM and receive datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      rx_byte    <= 8'h00;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rx_shift   <= rx_shift_n;
      rx_byte    <= rx_byte_n;
      wd_cnt     <= wd_cnt_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // Next-state logic: an edge always wins over a watchdog expiry in the same cycle
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    rx_shift_n   = rx_shift;
    rx_byte_n    = rx_byte;
    wd_cnt_n     = wd_cnt;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
`ifdef HACK_KBD_PARITY_CHECK_EN
    parity_bit_n = parity_bit;
`endif
    if (ps2_fall) begin
      wd_cnt_n = '0;
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          rx_shift_n = {data_s2, rx_shift[7:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
`ifdef HACK_KBD_PARITY_CHECK_EN
          parity_bit_n = data_s2;
`endif
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_s2 && parity_ok) begin
            byte_valid_n = 1'b1;
            rx_byte_n    = rx_shift;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (wd_cnt == WD_LIMIT) begin
        state_n  = IDLE;
        wd_cnt_n = '0;
      end else begin
        wd_cnt_n = wd_cnt + 1'b1;
      end
    end
  end

  assign make_code = map_key(ext_flag, l_shift | r_shift, rx_byte);
  assign lo_code   = map_key(ext_flag, 1'b0, rx_byte);
  assign hi_code   = map_key(ext_flag, 1'b1, rx_byte);

  // Key decoder: a release clears the output if it matches the key under
  // either shift state, so letting go of shift first still clears the key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hack_scancode <= 8'h00;
      key_strobe    <= 1'b0;
      ext_flag      <= 1'b0;
      brk_flag      <= 1'b0;
      l_shift       <= 1'b0;
      r_shift       <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (rx_byte == 8'h12) l_shift <= ~brk_flag;
          if (rx_byte == 8'h59) r_shift <= ~brk_flag;
          if (make_code != 8'h00) begin
            if (!brk_flag) begin
              hack_scancode <= make_code;
              key_strobe    <= 1'b1;
            end else if (hack_scancode == lo_code || hack_scancode == hi_code) begin
              hack_scancode <= 8'h00;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_keyboard.sv
// tb_hack_keyboard: self-checking bench for hack_keyboard.
// Table of directed frames, hand-timed corner sequences, then randomized
// key events compared against a layout-table reference model.
module tb_hack_keyboard;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] hack_scancode;
  logic       key_strobe;
  logic       frame_err;

  hack_keyboard #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .hack_scancode(hack_scancode),
    .key_strobe   (key_strobe),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (key_strobe) strobe_cnt++;
    if (frame_err)  err_cnt++;
  end

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp;
    int         strobes;
  } vec_t;
  vec_t vecs[$];

  // Reference model: layout tables plus held/shift/prefix state
  int base_map[int];
  int shift_map[int];
  int ext_map[int];
  int m_held, m_strobes;
  bit m_lsh, m_rsh, m_ext, m_brk;

  int letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                            8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                            8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                            8'h35, 8'h1A};
  int sym_codes [21] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                         8'h3E, 8'h46, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
                         8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  int sym_lo [21] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                      8'h38, 8'h39, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
                      8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  int sym_hi [21] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                      8'h2A, 8'h28, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
                      8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  int fkey_codes [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                          8'h01, 8'h09, 8'h78, 8'h07};
  int ext_codes [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                         8'h70, 8'h71};
  logic [8:0] pool [24] = '{9'h01C, 9'h032, 9'h021, 9'h015, 9'h01A, 9'h016, 9'h045,
                            9'h04E, 9'h052, 9'h05D, 9'h012, 9'h059, 9'h029, 9'h05A,
                            9'h066, 9'h076, 9'h005, 9'h083, 9'h175, 9'h16B, 9'h171,
                            9'h15A, 9'h06B, 9'h00D};

  task automatic build_maps();
    for (int i = 0; i < 26; i++) begin
      base_map[letter_codes[i]]  = 8'h61 + i;
      shift_map[letter_codes[i]] = 8'h41 + i;
    end
    for (int i = 0; i < 21; i++) begin
      base_map[sym_codes[i]]  = sym_lo[i];
      shift_map[sym_codes[i]] = sym_hi[i];
    end
    for (int i = 0; i < 12; i++) base_map[fkey_codes[i]] = 141 + i;
    for (int i = 0; i < 10; i++) ext_map[ext_codes[i]] = 130 + i;
    base_map[8'h29] = 32;
    base_map[8'h5A] = 128;
    base_map[8'h66] = 129;
    base_map[8'h76] = 140;
    ext_map[8'h5A]  = 128;
  endtask

  function automatic int lookup(bit e, bit s, int b);
    if (e) return ext_map.exists(b) ? ext_map[b] : 0;
    if (s && shift_map.exists(b)) return shift_map[b];
    return base_map.exists(b) ? base_map[b] : 0;
  endfunction

  task automatic model_clear();
    m_held = 0; m_strobes = 0;
    m_lsh = 0; m_rsh = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input int b);
    int code;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      code = lookup(m_ext, m_lsh | m_rsh, b);
      if (code != 0) begin
        if (!m_brk) begin
          m_held = code;
          m_strobes++;
        end else if (m_held == lookup(m_ext, 0, b) || m_held == lookup(m_ext, 1, b)) begin
          m_held = 0;
        end
      end
      if (b == 8'h12) m_lsh = !m_brk;
      if (b == 8'h59) m_rsh = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_stop,
                                             input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Drives n bits LSB first; returns right after the last falling edge
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      ps2_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i != n - 1) repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic release_line();
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic bad_stop, input logic bad_par);
    send_bits(make_frame(b, bad_stop, bad_par), 11);
    release_line();
  endtask

  task automatic add_vec(input logic [7:0] c, input logic [7:0] e, input int s);
    vec_t v;
    v.code = c; v.exp = e; v.strobes = s;
    vecs.push_back(v);
  endtask

  task automatic send_and_check(input string name, input logic [7:0] b,
                                input logic [7:0] exp_code, input int exp_strobes);
    int s0;
    s0 = strobe_cnt;
    applyStimulus(b, 1'b0, 1'b0);
    checkOutput({name, "_code"}, 32'(hack_scancode), 32'(exp_code));
    checkOutput({name, "_strobes"}, 32'(strobe_cnt - s0), 32'(exp_strobes));
  endtask

  initial begin
    int s0, e0;
    logic [10:0] bits;
    logic [7:0]  rb;
    logic [8:0]  k;
    bit          brk;
    logic [7:0]  seq[$];

    build_maps();

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_code", 32'(hack_scancode), 0);
    checkOutput("reset_strobe", 32'(key_strobe), 0);
    checkOutput("reset_err", 32'(frame_err), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Latency of a letter make: code lands two cycles after stop-edge detect
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("lat_n1_code", 32'(hack_scancode), 0);
    checkOutput("lat_n1_strobe", 32'(key_strobe), 0);
    @(posedge clk); #1;
    checkOutput("lat_n2_code", 32'(hack_scancode), 32'h61);
    checkOutput("lat_n2_strobe", 32'(key_strobe), 1);
    @(posedge clk); #1;
    checkOutput("lat_n3_strobe", 32'(key_strobe), 0);
    release_line();

    // Directed frame table
    add_vec(8'hF0, 8'h61, 0); add_vec(8'h1C, 8'h00, 0);
    add_vec(8'h12, 8'h00, 0); add_vec(8'h1C, 8'h41, 1);
    add_vec(8'hF0, 8'h41, 0); add_vec(8'h12, 8'h41, 0);
    add_vec(8'hF0, 8'h41, 0); add_vec(8'h1C, 8'h00, 0);
    add_vec(8'h1C, 8'h61, 1); add_vec(8'hF0, 8'h61, 0); add_vec(8'h1C, 8'h00, 0);
    add_vec(8'hE0, 8'h00, 0); add_vec(8'h75, 8'd131, 1);
    add_vec(8'hE0, 8'd131, 0); add_vec(8'hF0, 8'd131, 0); add_vec(8'h75, 8'h00, 0);
    add_vec(8'h1C, 8'h61, 1); add_vec(8'h1C, 8'h61, 1);
    add_vec(8'hF0, 8'h61, 0); add_vec(8'h1C, 8'h00, 0);
    add_vec(8'h1C, 8'h61, 1); add_vec(8'h32, 8'h62, 1);
    add_vec(8'hF0, 8'h62, 0); add_vec(8'h1C, 8'h62, 0);
    add_vec(8'hF0, 8'h62, 0); add_vec(8'h32, 8'h00, 0);
    add_vec(8'h5A, 8'd128, 1); add_vec(8'hF0, 8'd128, 0); add_vec(8'h5A, 8'h00, 0);
    add_vec(8'hE0, 8'h00, 0); add_vec(8'h5A, 8'd128, 1);
    add_vec(8'hE0, 8'd128, 0); add_vec(8'hF0, 8'd128, 0); add_vec(8'h5A, 8'h00, 0);
    add_vec(8'h07, 8'd152, 1); add_vec(8'hF0, 8'd152, 0); add_vec(8'h07, 8'h00, 0);
    add_vec(8'h83, 8'd147, 1); add_vec(8'hF0, 8'd147, 0); add_vec(8'h83, 8'h00, 0);
    add_vec(8'h66, 8'd129, 1); add_vec(8'hF0, 8'd129, 0); add_vec(8'h66, 8'h00, 0);
    add_vec(8'h76, 8'd140, 1); add_vec(8'hF0, 8'd140, 0); add_vec(8'h76, 8'h00, 0);
    add_vec(8'h6B, 8'h00, 0);
    add_vec(8'hE0, 8'h00, 0); add_vec(8'h6B, 8'd130, 1);
    add_vec(8'hE0, 8'd130, 0); add_vec(8'hF0, 8'd130, 0); add_vec(8'h6B, 8'h00, 0);
    add_vec(8'h59, 8'h00, 0); add_vec(8'h16, 8'h21, 1);
    add_vec(8'hF0, 8'h21, 0); add_vec(8'h16, 8'h00, 0);
    add_vec(8'h45, 8'h29, 1); add_vec(8'hF0, 8'h29, 0); add_vec(8'h59, 8'h29, 0);
    add_vec(8'hF0, 8'h29, 0); add_vec(8'h45, 8'h00, 0);
    add_vec(8'h29, 8'h20, 1); add_vec(8'hF0, 8'h20, 0); add_vec(8'h29, 8'h00, 0);
    for (int i = 0; i < vecs.size(); i++)
      send_and_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp, vecs[i].strobes);

    // Bad stop bit: error pulse at N+1, held code untouched
    send_and_check("pre_err", 8'h32, 8'h62, 1);
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stop_err_n1", 32'(frame_err), 1);
    @(posedge clk); #1;
    checkOutput("stop_err_n2", 32'(frame_err), 0);
    checkOutput("stop_err_code", 32'(hack_scancode), 32'h62);
    release_line();
    checkOutput("stop_err_count", 32'(err_cnt - e0), 1);

    // Bad parity frame
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b1);
`ifdef HACK_KBD_PARITY_CHECK_EN
    checkOutput("par_err_count", 32'(err_cnt - e0), 1);
    checkOutput("par_err_code", 32'(hack_scancode), 32'h62);
`else
    checkOutput("par_err_count", 32'(err_cnt - e0), 0);
    checkOutput("par_err_code", 32'(hack_scancode), 32'h61);
`endif
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    send_and_check("post_par", 8'h32, 8'h00, 0);

    // Pause shorter than the watchdog: frame still completes
    bits = make_frame(8'h1C, 1'b0, 1'b0);
    send_bits(bits, 5);
    release_line();
    repeat (TIMEOUT / 2) @(negedge clk);
    send_bits(bits >> 5, 6);
    release_line();
    checkOutput("short_gap_code", 32'(hack_scancode), 32'h61);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    send_and_check("short_gap_brk", 8'h1C, 8'h00, 0);

    // Partial frame abandoned by the watchdog
    e0 = err_cnt;
    send_bits(bits, 5);
    release_line();
    repeat (TIMEOUT + 20) @(negedge clk);
    send_and_check("timeout_esc", 8'h76, 8'd140, 1);
    checkOutput("timeout_no_err", 32'(err_cnt - e0), 0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    send_and_check("timeout_brk", 8'h76, 8'h00, 0);

    // Reset mid-frame clears outputs and shift
    applyStimulus(8'h12, 1'b0, 1'b0);
    send_and_check("rst_pre", 8'h1C, 8'h41, 1);
    send_bits(make_frame(8'h32, 1'b0, 1'b0), 5);
    @(negedge clk);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_mid_code", 32'(hack_scancode), 0);
    checkOutput("rst_mid_strobe", 32'(key_strobe), 0);
    checkOutput("rst_mid_err", 32'(frame_err), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_and_check("rst_post", 8'h32, 8'h62, 1);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    send_and_check("rst_post_brk", 8'h32, 8'h00, 0);

    // Randomized key events against the reference model
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    model_clear();
    for (int it = 0; it < 150; it++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      if ($urandom_range(0, 9) == 0) begin
        rb = 8'($urandom_range(0, 255));
        applyStimulus(rb, 1'b1, 1'b0);
        checkOutput($sformatf("rnd%0d_err", it), 32'(err_cnt - e0), 1);
      end else begin
        k   = pool[$urandom_range(0, 23)];
        brk = ($urandom_range(0, 99) < 40);
        seq.delete();
        if (k[8]) seq.push_back(8'hE0);
        if (brk)  seq.push_back(8'hF0);
        seq.push_back(k[7:0]);
        m_strobes = 0;
        foreach (seq[j]) begin
          applyStimulus(seq[j], 1'b0, 1'b0);
          model_byte(int'(seq[j]));
        end
        checkOutput($sformatf("rnd%0d_strobes", it), 32'(strobe_cnt - s0), 32'(m_strobes));
      end
      checkOutput($sformatf("rnd%0d_code", it), 32'(hack_scancode), 32'(m_held));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
